// File: rtl/ahbl_wrr_scheduler.sv
// ahbl_wrr_scheduler: weighted round-robin grant scheduler for an N:1 AHB-Lite
// arbiter, with HMASTLOCK hold. All state advances only on hready=1.
// Optional feature macro: AHBL_WRR_SCHED_LOCK_TIMEOUT_EN (forced lock release
// after LOCK_TIMEOUT cycles, signalled by a one-cycle lock_timeout pulse).
module ahbl_wrr_scheduler #(
  parameter int N_PORTS      = 4,
  parameter int W_WEIGHT     = 4,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS*W_WEIGHT-1:0]   cfg_weight,
  input  logic [N_PORTS-1:0]            req,
  input  logic [N_PORTS-1:0]            lock,
  input  logic                          hready,
  output logic [N_PORTS-1:0]            gnt,
  output logic [N_PORTS-1:0]            gnt_d,
  output logic                          lock_active,
  output logic                          lock_timeout
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {
    S_ARB  = 2'd0,
    S_HOLD = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t                state_q;
  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         owner_q;
  logic [W_WEIGHT-1:0]   credit_q;
  logic [N_PORTS-1:0]    gnt_d_q;
  logic                  lock_active_q;

  logic [N_PORTS-1:0]    gnt_s;
  logic [PW-1:0]         gnt_idx_s;
  logic [W_WEIGHT-1:0]   wsel_s;
  logic [W_WEIGHT-1:0]   credit_start_s;

  // First requester at or after 'start', wrapping at the top port.
  function automatic logic [N_PORTS-1:0] rr_pick(input logic [PW-1:0] start,
                                                 input logic [N_PORTS-1:0] r);
    logic [N_PORTS-1:0] pick;
    logic               found;
    int                 idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < N_PORTS; off++) begin
      idx = (int'(start) + off) % N_PORTS;
      if (!found && r[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  // Index of the set bit of a onehot vector (0 when empty).
  function automatic logic [PW-1:0] oh_enc(input logic [N_PORTS-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (oh[i]) begin
        idx = PW'(i);
      end
    end
    return idx;
  endfunction

  // Successor port index, wrapping to 0.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == PW'(N_PORTS - 1)) ? '0 : i + PW'(1);
  endfunction

  // Address-phase grant: owner is held in HOLD/LOCK, otherwise round-robin.
  // A HOLD owner that drops its request hands over in the same cycle.
  always_comb begin
    gnt_s = '0;
    case (state_q)
      S_ARB: begin
        gnt_s = rr_pick(ptr_q, req);
      end
      S_HOLD: begin
        if (req[owner_q]) begin
          gnt_s = N_PORTS'(1) << owner_q;
        end else begin
          gnt_s = rr_pick(next_idx(owner_q), req);
        end
      end
      S_LOCK: begin
        gnt_s = N_PORTS'(1) << owner_q;
      end
      default: begin
        gnt_s = '0;
      end
    endcase
    if (rst) begin
      gnt_s = '0;
    end else begin
      gnt_s = gnt_s;
    end
  end

  // Weight of the port being granted, with 0 treated as 1, minus the
  // transfer that starts the turn.
  always_comb begin
    gnt_idx_s      = oh_enc(gnt_s);
    wsel_s         = cfg_weight[gnt_idx_s*W_WEIGHT +: W_WEIGHT];
    credit_start_s = '0;
    if (wsel_s == '0) begin
      credit_start_s = '0;
    end else begin
      credit_start_s = wsel_s - W_WEIGHT'(1);
    end
  end

`ifdef AHBL_WRR_SCHED_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1) + 1;
  logic [CW-1:0] lock_cnt_q;
  logic          lock_timeout_q;
  assign lock_timeout = lock_timeout_q;
`else
  // No timeout hardware: a lock is held for as long as the master asks.
  assign lock_timeout = 1'b0 & (LOCK_TIMEOUT > 0);
`endif

  // Scheduler FSM: pointer, owner, credit, data-phase owner and lock status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_ARB;
      ptr_q         <= '0;
      owner_q       <= '0;
      credit_q      <= '0;
      gnt_d_q       <= '0;
      lock_active_q <= 1'b0;
`ifdef AHBL_WRR_SCHED_LOCK_TIMEOUT_EN
      lock_cnt_q     <= '0;
      lock_timeout_q <= 1'b0;
`endif
    end else begin
`ifdef AHBL_WRR_SCHED_LOCK_TIMEOUT_EN
      lock_timeout_q <= 1'b0;
`endif
      if (hready) begin
        gnt_d_q <= gnt_s & (req | {N_PORTS{state_q == S_LOCK}});
        case (state_q)
          S_LOCK: begin
            if (!lock[owner_q]) begin
              state_q       <= S_ARB;
              ptr_q         <= next_idx(owner_q);
              lock_active_q <= 1'b0;
            end
`ifdef AHBL_WRR_SCHED_LOCK_TIMEOUT_EN
            else if (lock_cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
              state_q        <= S_ARB;
              ptr_q          <= next_idx(owner_q);
              lock_active_q  <= 1'b0;
              lock_timeout_q <= 1'b1;
            end else begin
              lock_cnt_q <= lock_cnt_q + CW'(1);
            end
`endif
          end
          S_ARB, S_HOLD: begin
            if (state_q == S_HOLD && req[owner_q]) begin
              // Continuing turn; a locked transfer overrides credit counting.
              if (lock[owner_q]) begin
                state_q       <= S_LOCK;
                lock_active_q <= 1'b1;
`ifdef AHBL_WRR_SCHED_LOCK_TIMEOUT_EN
                lock_cnt_q    <= '0;
`endif
              end else if (credit_q <= W_WEIGHT'(1)) begin
                credit_q <= '0;
                ptr_q    <= next_idx(owner_q);
                state_q  <= S_ARB;
              end else begin
                credit_q <= credit_q - W_WEIGHT'(1);
              end
            end else if (gnt_s != '0) begin
              // New turn start (also after a HOLD owner walked away).
              owner_q <= gnt_idx_s;
              if (lock[gnt_idx_s]) begin
                state_q       <= S_LOCK;
                lock_active_q <= 1'b1;
`ifdef AHBL_WRR_SCHED_LOCK_TIMEOUT_EN
                lock_cnt_q    <= '0;
`endif
              end else if (credit_start_s != '0) begin
                credit_q <= credit_start_s;
                state_q  <= S_HOLD;
              end else begin
                credit_q <= '0;
                ptr_q    <= next_idx(gnt_idx_s);
                state_q  <= S_ARB;
              end
            end else begin
              // Nobody to grant: an abandoned HOLD turn still passes the pointer on.
              if (state_q == S_HOLD) begin
                ptr_q <= next_idx(owner_q);
              end
              state_q <= S_ARB;
            end
          end
          default: begin
            state_q <= S_ARB;
          end
        endcase
      end
    end
  end

  assign gnt         = gnt_s;
  assign gnt_d       = gnt_d_q;
  assign lock_active = lock_active_q;

endmodule

// File: tb/tb_ahbl_wrr_scheduler.sv
// Scoreboard bench for ahbl_wrr_scheduler: the driver pushes hand-computed
// expectations per cycle, a monitor pops and compares on the falling edge.
module tb_ahbl_wrr_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_weight = 16'h1111;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  lock = 4'b0000;
  logic        hready = 1'b1;
  logic [3:0]  gnt;
  logic [3:0]  gnt_d;
  logic        lock_active;
  logic        lock_timeout;

  typedef struct {
    logic [3:0] g;
    logic [3:0] gd;
    logic       la;
    logic       lt;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  ahbl_wrr_scheduler #(.N_PORTS(4), .W_WEIGHT(4), .LOCK_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_weight   (cfg_weight),
    .req          (req),
    .lock         (lock),
    .hready       (hready),
    .gnt          (gnt),
    .gnt_d        (gnt_d),
    .lock_active  (lock_active),
    .lock_timeout (lock_timeout)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs, queue its expected outputs, advance to next cycle.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                      input logic hr, input logic [3:0] eg, input logic [3:0] egd,
                      input logic ela, input logic elt, input string nm);
    exp_t e;
    rst    = r;
    req    = rq;
    lock   = lk;
    hready = hr;
    e.g  = eg;
    e.gd = egd;
    e.la = ela;
    e.lt = elt;
    e.nm = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if (gnt !== e.g || gnt_d !== e.gd || lock_active !== e.la || lock_timeout !== e.lt) begin
          bad++;
          $display("FAIL %s: got gnt=%b gnt_d=%b la=%b lt=%b, want gnt=%b gnt_d=%b la=%b lt=%b",
                   e.nm, gnt, gnt_d, lock_active, lock_timeout, e.g, e.gd, e.la, e.lt);
        end
      end
    end
  end

  initial begin
    int waited;
    @(posedge clk);
    #1;
    // Reset: grant forced low, registers cleared.
    step(1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "reset");
    // Plain round-robin, all weights 1.
    step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, "rr_p0");
    step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0010, 4'b0001, 1'b0, 1'b0, "rr_p1");
    step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0100, 4'b0010, 1'b0, 1'b0, "rr_p2");
    step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b1000, 4'b0100, 1'b0, 1'b0, "rr_p3");
    step(1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b1000, 1'b0, 1'b0, "rr_wrap");
    // Port0 weight 3, requests on ports 0 and 1.
    cfg_weight = 16'h1113;
    step(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0010, 4'b0001, 1'b0, 1'b0, "w_p1a");
    step(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, 4'b0010, 1'b0, 1'b0, "w_p0a1");
    step(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, "w_p0a2");
    step(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, "w_p0a3");
    step(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0010, 4'b0001, 1'b0, 1'b0, "w_p1b");
    step(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, 4'b0010, 1'b0, 1'b0, "w_p0b1");
    step(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, "w_p0b2");
    step(1'b0, 4'b0011, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, "w_p0b3");
    // Credit abandoned when the HOLD owner drops its request.
    step(1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0100, 4'b0001, 1'b0, 1'b0, "ab_p2");
    step(1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0001, 4'b0100, 1'b0, 1'b0, "ab_p0");
    step(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0100, 4'b0001, 1'b0, 1'b0, "ab_handover");
    step(1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0001, 4'b0100, 1'b0, 1'b0, "fr_start");
    // hready low mid-HOLD with credit 2: everything frozen.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'b0101, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, "freeze");
    end
    step(1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, "fr_cont1");
    step(1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, "fr_cont2");
    step(1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0100, 4'b0001, 1'b0, 1'b0, "fr_next");
    // Lock by port2, held through an IDLE stretch.
    step(1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0, "lk_enter");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1011, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, "lk_hold");
    end
    step(1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, "lk_release");
    step(1'b0, 4'b1011, 4'b0000, 1'b1, 4'b1000, 4'b0100, 1'b0, 1'b0, "lk_after");
    step(1'b0, 4'b1011, 4'b0000, 1'b1, 4'b0001, 4'b1000, 1'b0, 1'b0, "lk_after2");
    // HOLD handover straight into a lock by port1.
    step(1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0001, 1'b0, 1'b0, "lk1_enter");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'b0011, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, "lk1_hold");
    end
`ifdef AHBL_WRR_SCHED_LOCK_TIMEOUT_EN
    step(1'b0, 4'b0011, 4'b0010, 1'b1, 4'b0001, 4'b0010, 1'b0, 1'b1, "to_pulse");
    step(1'b0, 4'b0011, 4'b0010, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, "to_after");
    step(1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0001, 1'b0, 1'b0, "to_relock");
`else
    step(1'b0, 4'b0011, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, "lk1_long1");
    step(1'b0, 4'b0011, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, "lk1_long2");
    step(1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, "lk1_long3");
`endif
    step(1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, "lk1_locked");
    // Reset mid-LOCK.
    step(1'b1, 4'b0010, 4'b0010, 1'b1, 4'b0000, 4'b0010, 1'b1, 1'b0, "rst_mid_lock");
    step(1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, "post_rst");
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0010, 1'b0, 1'b0, "no_req1");
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, "no_req2");

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
